data_stack: RTL
===============

Name: data_stack

Overview:
Forth data stack that sits directly upstream of the ALU.
- Presents top-of-stack (TOS) as ALU operand B and next-on-stack (NOS) as ALU operand A, so `a b -` computes A-B.
- Consumes the ALU result on binary and unary operations.
- TOS and NOS are held in registers; deeper entries spill into a small register-file RAM.
- Every operation completes in one cycle.

Parameters:
- DEPTH, 32, total stack capacity in entries, counting TOS and NOS; must be ≥ 3.
- WIDTH, 16, data width; matches the ALU operand width.
- DW, 6, width of the depth counter; must satisfy 2^DW > DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  3  stack operation, encoded per the shared defines; 0 means NOP.
- din  in  WIDTH  literal or memory value for PUSH.
- res  in  WIDTH  ALU result, consumed by BINOP and UNOP.
- tos  out  WIDTH  top of stack; drives ALU B.
- nos  out  WIDTH  second entry; drives ALU A.
- depth  out  DW  current number of valid entries, 0..DEPTH.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.

Behaviour:
- Reset: clk and a synchronous active-high rst, as already decided.
  - On rst: tos=0, nos=0, depth=0, err_ovf=0, err_unf=0. RAM contents are don't-care.
  - rst has priority over any op in the same cycle, so a reset mid-sequence discards that op.
- Timing: all outputs are registered. An op sampled at edge N is visible after edge N.
  - res is sampled combinationally on the same edge as the op, so the ALU path is tos/nos → alu → res → data_stack within one cycle.
- Spill RAM:
  - DEPTH-2 entries, synchronous write, asynchronous read.
  - Spill pointer sp = depth-2 when depth > 2, else 0.
  - Entry ram[sp-1] is the third stack element.
- Refill rule: when a register vacates and there is no deeper valid entry, it loads 0. Slots beyond depth therefore always read 0.
- Operations (d = depth before the op):
  - NOP (0): no change.
  - PUSH (1), requires d < DEPTH.
    - If d ≥ 2: ram[sp] ← nos.
    - nos ← tos; tos ← din; depth ← d+1.
  - DROP (2), requires d ≥ 1.
    - tos ← nos.
    - nos ← ram[sp-1] if d > 2, else 0.
    - depth ← d-1.
  - BINOP (3), requires d ≥ 2.
    - tos ← res.
    - nos ← ram[sp-1] if d > 2, else 0.
    - depth ← d-1.
  - UNOP (4), requires d ≥ 1: tos ← res; depth unchanged.
  - DUP (5), requires 1 ≤ d < DEPTH.
    - If d ≥ 2: ram[sp] ← nos.
    - nos ← tos; depth ← d+1.
  - SWAP (6), requires d ≥ 2: tos ↔ nos.
  - OVER (7), requires 2 ≤ d < DEPTH.
    - If d ≥ 2: ram[sp] ← nos.
    - nos ← tos; tos ← old nos; depth ← d+1.
- Illegal op (requirement not met):
  - State, depth and RAM are all unchanged.
  - err_unf is set if the lower bound failed; err_ovf is set if the upper bound failed.
  - Flags stay set until rst.
  - Later legal ops still execute normally.
- Boundaries:
  - d = DEPTH: PUSH, DUP and OVER are rejected (overflow).
  - d = 0: DROP, UNOP, BINOP, DUP, SWAP and OVER are rejected (underflow).
  - d = 1: BINOP, SWAP and OVER are rejected (underflow).
  - The depth counter never wraps.
- Arithmetic: data is passed through unmodified. The block performs no sign or width handling.

Decomposition:
- Shared include forth_defs.vh holds:
  - op encodings OP_NOP … OP_OVER;
  - WIDTH default;
  - ALU opcode constants, shared with the decoder.
- One sub-module, stack_ram: parameterised depth/width, one synchronous write port, one asynchronous read port.
- TOS/NOS registers, depth counter and error logic stay in data_stack.

Test Plan:
- Reset, then PUSH 5, PUSH 3 → tos=3, nos=5, depth=2; drive res=2 with BINOP → tos=2, nos=0, depth=1.
- PUSH 1,2,3,4,5 then DROP ×5 → tos goes 4,3,2,1,0 in turn (spill refill); depth ends at 0; no error flags set.
- PUSH 7, DUP → tos=7, nos=7, depth=2; PUSH 9, SWAP → tos=7, nos=9; OVER → tos=9, nos=7, depth=4.
- PUSH 32 values (0..31) then PUSH 99 → err_ovf=1, depth=32, tos=31; then DROP → tos=30, depth=31, err_ovf still 1.
- From reset: DROP → err_unf=1, depth=0, tos=0; PUSH 4, BINOP → err_unf stays 1, tos=4, depth=1; UNOP with res=0xFFFB → tos=0xFFFB.
- PUSH 6, PUSH 8, then assert rst in the same cycle as PUSH 1 → next cycle tos=0, nos=0, depth=0, flags cleared.

Source files
------------

// File: rtl/data_stack_pkg.sv
// Shared definitions for the Forth core: stack op encodings, the ALU opcode set
// the decoder also uses, and per-op depth requirements.
package data_stack_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_DROP  = 3'd2,
        OP_BINOP = 3'd3,
        OP_UNOP  = 3'd4,
        OP_DUP   = 3'd5,
        OP_SWAP  = 3'd6,
        OP_OVER  = 3'd7
    } stack_op_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_NEG = 4'd6,
        ALU_SHL = 4'd7,
        ALU_SHR = 4'd8
    } alu_op_e;

    // Minimum stack depth an op needs before it may execute.
    function automatic logic [1:0] op_min_depth(input stack_op_e op);
        logic [1:0] min_d;
        case (op)
            OP_DROP, OP_UNOP, OP_DUP:  min_d = 2'd1;
            OP_BINOP, OP_SWAP, OP_OVER: min_d = 2'd2;
            default:                   min_d = 2'd0;
        endcase
        return min_d;
    endfunction

    // Ops that add one entry and are therefore bounded by capacity.
    function automatic logic op_grows(input stack_op_e op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Operand/result bundle between the decoder/ALU side and the data stack.
interface data_stack_if #(
    parameter int WIDTH = 16,
    parameter int DW    = 6
);
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DW-1:0]    depth;
    logic             err_ovf;
    logic             err_unf;

    modport master (
        output op, din, res,
        input  tos, nos, depth, err_ovf, err_unf
    );

    modport slave (
        input  op, din, res,
        output tos, nos, depth, err_ovf, err_unf
    );
endinterface

// File: rtl/stack_ram.sv
// Spill storage for stack entries below NOS: one synchronous write port and
// one asynchronous read port so a refill completes in the same cycle.
module stack_ram #(
    parameter int ENTRIES = 30,
    parameter int WIDTH   = 16,
    parameter int AW      = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_stack.sv
// Forth data stack: TOS/NOS in registers feeding the ALU, deeper entries in a
// spill RAM; every op completes in one cycle, illegal ops only raise flags.
module data_stack
    import data_stack_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DW    = 6
) (
    input  logic         clk,
    input  logic         rst,
    data_stack_if.slave  bus
);

    localparam int RAM_DEPTH = DEPTH - 2;
    localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
    localparam logic [DW-1:0] TWO_C   = DW'(2);

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    stack_op_e        op_e;
    logic             deep;
    logic [AW-1:0]    sp;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] refill;
    logic             ram_we;
    logic             lo_fail;
    logic             hi_fail;

    assign op_e    = stack_op_e'(bus.op);
    assign deep    = depth_q > TWO_C;
    assign sp      = deep ? AW'(depth_q - TWO_C) : '0;
    assign rd_addr = sp - AW'(1);
    // With no third element, a vacated NOS loads zero so slots past depth read 0.
    assign refill  = deep ? rd_data : '0;

    assign lo_fail = depth_q < DW'(op_min_depth(op_e));
    assign hi_fail = op_grows(op_e) && (depth_q >= DEPTH_C);

    stack_ram #(
        .ENTRIES (RAM_DEPTH),
        .WIDTH   (WIDTH),
        .AW      (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (sp),
        .wdata_i (nos_q),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        tos_d   = tos_q;
        nos_d   = nos_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        ram_we  = 1'b0;
        if (lo_fail || hi_fail) begin
            unf_d = unf_q | lo_fail;
            ovf_d = ovf_q | hi_fail;
        end else begin
            case (op_e)
                OP_PUSH: begin
                    ram_we  = depth_q >= TWO_C;
                    nos_d   = tos_q;
                    tos_d   = bus.din;
                    depth_d = depth_q + DW'(1);
                end
                OP_DROP: begin
                    tos_d   = nos_q;
                    nos_d   = refill;
                    depth_d = depth_q - DW'(1);
                end
                OP_BINOP: begin
                    tos_d   = bus.res;
                    nos_d   = refill;
                    depth_d = depth_q - DW'(1);
                end
                OP_UNOP: begin
                    tos_d = bus.res;
                end
                OP_DUP: begin
                    ram_we  = depth_q >= TWO_C;
                    nos_d   = tos_q;
                    depth_d = depth_q + DW'(1);
                end
                OP_SWAP: begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end
                OP_OVER: begin
                    ram_we  = 1'b1;
                    nos_d   = tos_q;
                    tos_d   = nos_q;
                    depth_d = depth_q + DW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.tos     = tos_q;
    assign bus.nos     = nos_q;
    assign bus.depth   = depth_q;
    assign bus.err_ovf = ovf_q;
    assign bus.err_unf = unf_q;

endmodule
